// File: rtl/conv4_feeder_pkg.sv
// Shared types and constants for the Conv4_core streaming feeder.
package conv4_feeder_pkg;

  localparam int conv4_width = 8;
  localparam int CONV4_ROWS  = 4;
  localparam int CONV4_K     = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    FLUSH    = 3'd2,
    WAIT_END = 3'd3,
    DONE     = 3'd4
  } conv4_feed_state_t;

endpackage

// File: rtl/conv4_feeder_stripe_buf.sv
// 4 x IMG_W stripe register file: one write port, one column-wide
// combinational read port. Contents survive reset on purpose so a pass
// can be replayed after an abort.
module conv4_stripe_buf
  import conv4_feeder_pkg::*;
#(
  parameter int IMG_W = 4
) (
  input  logic                                          clk,
  input  logic                                          we,
  input  logic [1:0]                                    wr_row,
  input  logic [$clog2(IMG_W)-1:0]                      wr_col,
  input  logic [conv4_width-1:0]                        wr_data,
  input  logic [$clog2(IMG_W)-1:0]                      rd_col,
  output logic [CONV4_ROWS-1:0][conv4_width-1:0]        rd_data
);

  logic [conv4_width-1:0] mem [CONV4_ROWS][IMG_W];

  // Pixel write; the caller only asserts we for in-range columns.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  for (genvar r = 0; r < CONV4_ROWS; r++) begin : g_rd
    assign rd_data[r] = mem[r][rd_col];
  end

endmodule

// File: rtl/conv4_feeder.sv
// Streaming driver for Conv4_core: holds a 4-row stripe and a 3x3 kernel,
// and on start presents one stripe column per cycle (kernel columns on the
// first three), flushes with zeros, then holds en until end_conv4.
//
// Handshake: start is a single-cycle request accepted only in IDLE (ignored
// otherwise, never queued); end_conv4 is sampled every cycle of a pass and
// an early assertion during STREAM/FLUSH is remembered. No backpressure.
module conv4_feeder
  import conv4_feeder_pkg::*;
#(
  parameter int IMG_W     = 4,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_row,
  input  logic [$clog2(IMG_W)-1:0]     wr_col,
  input  logic [conv4_width-1:0]       wr_data,
  input  logic                         kw_en,
  input  logic [3:0]                   kw_idx,
  input  logic [conv4_width-1:0]       kw_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         en,
  output logic [conv4_width-1:0]       i_r1,
  output logic [conv4_width-1:0]       i_r2,
  output logic [conv4_width-1:0]       i_r3,
  output logic [conv4_width-1:0]       i_r4,
  output logic [conv4_width-1:0]       i_f1,
  output logic [conv4_width-1:0]       i_f2,
  output logic [conv4_width-1:0]       i_f3,
  input  logic                         end_conv4,
  output conv4_feed_state_t            dbg_state
);

  localparam int CW   = $clog2(IMG_W);
  localparam int FL_N = (FLUSH_CYC < 1) ? 1 : FLUSH_CYC;
  localparam int FW   = $clog2(FL_N + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  conv4_feed_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          early_q, early_d;
  logic          err_q, err_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CONV4_ROWS-1:0][conv4_width-1:0] r_q, r_d;
  logic [CONV4_K-1:0][conv4_width-1:0]    f_q, f_d;

  logic                                   wr_ok;
  logic                                   buf_we;
  logic                                   kern_we;
  logic [CW-1:0]                          rd_col;
  logic [CONV4_ROWS-1:0][conv4_width-1:0] rd_data;
  logic [CONV4_ROWS-1:0][conv4_width-1:0] col_data;
  logic [CONV4_K-1:0][conv4_width-1:0]    kcol;
  logic [conv4_width-1:0]                 kern [9];

  assign wr_ok   = (state_q == IDLE) || (state_q == DONE);
  assign buf_we  = wr_ok && wr_en && (32'(wr_col) < 32'(IMG_W));
  assign kern_we = wr_ok && kw_en && (kw_idx <= 4'd8);

  conv4_stripe_buf #(.IMG_W(IMG_W)) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  // Kernel store write; not cleared by reset.
  always_ff @(posedge clk) begin
    if (kern_we) begin
      kern[kw_idx] <= kw_data;
    end
  end

  // Column to load into the output registers at the next edge.
  always_comb begin
    rd_col = '0;
    if (state_q == STREAM && col_q != LAST_COL) begin
      rd_col = col_q + 1'b1;
    end
  end

  // Same-cycle writes are forwarded so a write alongside start is seen
  // by the very first column.
  for (genvar r = 0; r < CONV4_ROWS; r++) begin : g_col
    assign col_data[r] = (buf_we && wr_row == 2'(r) && wr_col == rd_col)
                         ? wr_data : rd_data[r];
  end

  for (genvar n = 0; n < CONV4_K; n++) begin : g_kcol
    logic [3:0] kidx;
    assign kidx    = 4'(rd_col) * 4'd3 + 4'(n);
    assign kcol[n] = (rd_col < CW'(CONV4_K))
                     ? ((kern_we && kw_idx == kidx) ? kw_data : kern[kidx])
                     : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      col_q   <= '0;
      fcnt_q  <= '0;
      timer_q <= '0;
      early_q <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      fcnt_q  <= fcnt_d;
      timer_q <= timer_d;
      early_q <= early_d;
      err_q   <= err_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      f_q     <= f_d;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fcnt_d  = fcnt_q;
    timer_d = timer_q;
    early_d = early_q;
    err_d   = err_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = '0;
    f_d     = '0;
    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = STREAM;
          col_d   = '0;
          fcnt_d  = '0;
          timer_d = '0;
          early_d = 1'b0;
          err_d   = 1'b0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          r_d     = col_data;
          f_d     = kcol;
        end
      end
      STREAM: begin
        early_d = early_q | end_conv4;
        if (col_q == LAST_COL) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else begin
          col_d = col_q + 1'b1;
          r_d   = col_data;
          f_d   = kcol;
        end
      end
      FLUSH: begin
        early_d = early_q | end_conv4;
        if (fcnt_q == FW'(FL_N - 1)) begin
          if (early_q || end_conv4) begin
            state_d = DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_END;
            timer_d = '0;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      WAIT_END: begin
        if (end_conv4) begin
          state_d = DONE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign en        = en_q;
  assign i_r1      = r_q[0];
  assign i_r2      = r_q[1];
  assign i_r3      = r_q[2];
  assign i_r4      = r_q[3];
  assign i_f1      = f_q[0];
  assign i_f2      = f_q[1];
  assign i_f3      = f_q[2];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv4_feeder.sv
// Bench for conv4_feeder: directed passes, a per-cycle trace model built
// from the stripe/kernel contents, and literal pins on key cycles.
module tb_conv4_feeder;
  import conv4_feeder_pkg::*;

  localparam int IMG_W     = 5;
  localparam int FLUSH_CYC = 1;
  localparam int TIMEOUT   = 16;
  localparam int CW        = $clog2(IMG_W);
  localparam int VW        = 4 + 7 * conv4_width;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   wr_en, kw_en, start, end_conv4;
  logic [1:0]             wr_row;
  logic [CW-1:0]          wr_col;
  logic [conv4_width-1:0] wr_data, kw_data;
  logic [3:0]             kw_idx;
  logic                   busy, done, err, en;
  logic [conv4_width-1:0] i_r1, i_r2, i_r3, i_r4, i_f1, i_f2, i_f3;
  conv4_feed_state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] tr[$];
  logic [VW-1:0] cur;
  logic [VW-1:0] act_vec;
  logic [7:0]    m_stripe [4][IMG_W];
  logic [7:0]    m_kern [9];
  logic          m_err;

  conv4_feeder #(.IMG_W(IMG_W), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .kw_en(kw_en), .kw_idx(kw_idx), .kw_data(kw_data),
    .start(start), .busy(busy), .done(done), .err(err), .en(en),
    .i_r1(i_r1), .i_r2(i_r2), .i_r3(i_r3), .i_r4(i_r4),
    .i_f1(i_f1), .i_f2(i_f2), .i_f3(i_f3),
    .end_conv4(end_conv4), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  assign act_vec = {en, busy, done, err, i_r1, i_r2, i_r3, i_r4, i_f1, i_f2, i_f3};

  function automatic logic [VW-1:0] pack(input logic en_v, input logic busy_v,
                                         input logic done_v, input logic err_v,
                                         input logic [31:0] r_v, input logic [23:0] f_v);
    return {en_v, busy_v, done_v, err_v, r_v, f_v};
  endfunction

  // Scoreboard compare: one expected vector per cycle while the queue is fed.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (act_vec !== cur) begin
        failures++;
        $display("FAIL trace t=%0t act=%h exp=%h", $time, act_vec, cur);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp_v);
    end
  endtask

  // Expected trace of a pass (cycles 1..done+1) from the model contents.
  task automatic build_trace(input int end_at, output logic err_new);
    int fl_end, done_k;
    logic [31:0] rv;
    logic [23:0] fv;
    fl_end = IMG_W + FLUSH_CYC;
    if (end_at >= 1 && end_at <= fl_end) begin
      done_k = fl_end + 1; err_new = 1'b0;
    end else if (end_at > fl_end && end_at <= fl_end + TIMEOUT) begin
      done_k = end_at + 1; err_new = 1'b0;
    end else begin
      done_k = fl_end + TIMEOUT + 1; err_new = 1'b1;
    end
    tr.delete();
    for (int k = 1; k < done_k; k++) begin
      rv = '0;
      fv = '0;
      if (k <= IMG_W) begin
        rv = {m_stripe[0][k-1], m_stripe[1][k-1], m_stripe[2][k-1], m_stripe[3][k-1]};
        if (k - 1 < 3) fv = {m_kern[(k-1)*3], m_kern[(k-1)*3+1], m_kern[(k-1)*3+2]};
      end
      tr.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, rv, fv));
    end
    tr.push_back(pack(1'b0, 1'b0, 1'b1, err_new, '0, '0));
    tr.push_back(pack(1'b0, 1'b0, 1'b0, err_new, '0, '0));
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en = 1'b0; kw_en = 1'b0; start = 1'b0; end_conv4 = 1'b0;
  endtask

  task automatic idle_cycle();
    next_cycle();
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_err, '0, '0));
  endtask

  task automatic write_pix(input int row, input int col, input logic [7:0] d);
    next_cycle();
    wr_en = 1'b1; wr_row = 2'(row); wr_col = CW'(col); wr_data = d;
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_err, '0, '0));
    if (col < IMG_W) m_stripe[row][col] = d;
  endtask

  task automatic write_kern(input int idx, input logic [7:0] d);
    next_cycle();
    kw_en = 1'b1; kw_idx = 4'(idx); kw_data = d;
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_err, '0, '0));
    if (idx <= 8) m_kern[idx] = d;
  endtask

  task automatic pin_checks(input int pin, input int k);
    if (pin == 1) begin
      case (k)
        1: begin
          chk("c1_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h01010101);
          chk("c1_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h00010203);
        end
        2: begin
          chk("c2_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h02020202);
          chk("c2_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h00040506);
        end
        3: chk("c3_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h00070809);
        4: begin
          chk("c4_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h04040404);
          chk("c4_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h00000000);
        end
        6: begin
          chk("flush_en", {31'h0, en}, 32'h1);
          chk("flush_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h0);
        end
        9: chk("done_ctl", {29'h0, en, done, err}, 32'h2);
        default: ;
      endcase
    end else if (pin == 2) begin
      if (k == 22) chk("to_en", {31'h0, en}, 32'h1);
      if (k == 23) chk("to_ctl", {29'h0, en, done, err}, 32'h3);
    end
  endtask

  // One pass. mode 1: writes and a second start while busy; mode 2: writes
  // in the start cycle. end_at is the cycle (after start) end_conv4 is high.
  task automatic run_pass(input int end_at, input int mode, input int pin);
    logic err_new;
    next_cycle();
    start = 1'b1;
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_err, '0, '0));
    if (mode == 2) begin
      wr_en = 1'b1; wr_row = 2'd2; wr_col = '0; wr_data = 8'hA5;
      kw_en = 1'b1; kw_idx = 4'd1; kw_data = 8'h5A;
      m_stripe[2][0] = 8'hA5;
      m_kern[1] = 8'h5A;
    end
    build_trace(end_at, err_new);
    for (int k = 1; k <= tr.size(); k++) begin
      next_cycle();
      end_conv4 = (k == end_at);
      if (mode == 1 && k == 2) begin
        wr_en = 1'b1; wr_row = 2'd1; wr_col = CW'(1); wr_data = 8'hEE;
        kw_en = 1'b1; kw_idx = 4'd4; kw_data = 8'hEE;
      end
      if (mode == 1 && k == 3) start = 1'b1;
      exp_q.push_back(tr[k-1]);
      if (pin != 0) begin
        @(negedge clk);
        pin_checks(pin, k);
      end
    end
    m_err = err_new;
  endtask

  task automatic reset_mid_pass();
    logic unused_err;
    next_cycle();
    start = 1'b1;
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_err, '0, '0));
    build_trace(-1, unused_err);
    next_cycle();
    exp_q.push_back(tr[0]);
    next_cycle();
    #2 rstn = 1'b0;
    #1;
    chk("rst_ctl", {28'h0, en, busy, done, err}, 32'h0);
    chk("rst_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h0);
    chk("rst_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h0);
    exp_q.delete();
    m_err = 1'b0;
    repeat (3) idle_cycle();
    rstn = 1'b1;
    idle_cycle();
  endtask

  initial begin
    rstn = 1'b0;
    wr_en = 1'b0; kw_en = 1'b0; start = 1'b0; end_conv4 = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; kw_idx = '0; kw_data = '0;
    m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {28'h0, en, busy, done, err}, 32'h0);
    chk("reset_rows", {i_r1, i_r2, i_r3, i_r4}, 32'h0);
    chk("reset_kern", {8'h0, i_f1, i_f2, i_f3}, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) write_kern(i, 8'(i + 1));
    for (int c = 0; c < IMG_W; c++)
      for (int r = 0; r < 4; r++) write_pix(r, c, 8'(c + 1));
    idle_cycle();
    run_pass(8, 0, 1);

    for (int c = 0; c < IMG_W; c++)
      for (int r = 0; r < 4; r++) write_pix(r, c, 8'(8'h10 * (r + 1) + c));
    for (int i = 0; i < 9; i++) write_kern(i, 8'(8'h30 + 3 * i));
    run_pass(-1, 0, 2);
    run_pass(2, 0, 0);
    run_pass(7, 1, 0);
    run_pass(10, 0, 0);

    write_pix(0, 5, 8'hFF);
    write_pix(3, 7, 8'hFF);
    write_kern(9, 8'hFF);
    write_kern(15, 8'hFF);
    run_pass(IMG_W + FLUSH_CYC + TIMEOUT, 0, 0);
    run_pass(6, 2, 0);

    reset_mid_pass();
    run_pass(7, 0, 0);
    repeat (3) idle_cycle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
